// File: rtl/fib_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// fib_seq_ctrl_if
// Command/status and datapath-control bundle for the Fibonacci sequence
// controller.
//   master : drives start/len/abort, observes the control and status outputs
//   slave  : the controller; receives start/len/abort, drives
//            wer/wea/addr1/addr2/addr3/src_sel/busy/done/err
// -----------------------------------------------------------------------------
interface fib_seq_ctrl_if;
  logic       start;    // request a new sequence (honoured only in IDLE)
  logic [5:0] len;      // total terms including both seeds, valid 3..63
  logic       abort;    // cancel a running sequence
  logic       wer;      // register-file write enable
  logic       wea;      // RAM write enable
  logic [5:0] addr1;    // read address A (older operand)
  logic [5:0] addr2;    // read address B (newer operand)
  logic [5:0] addr3;    // write address, shared by register file and RAM
  logic [1:0] src_sel;  // write-data mux: 0 seed A, 1 seed B, 2 ALU sum
  logic       busy;     // high in SEED0, SEED1 and CALC
  logic       done;     // one-cycle pulse on normal completion
  logic       err;      // one-cycle pulse when start has an invalid len

  modport master (
    output start, len, abort,
    input  wer, wea, addr1, addr2, addr3, src_sel, busy, done, err
  );

  modport slave (
    input  start, len, abort,
    output wer, wea, addr1, addr2, addr3, src_sel, busy, done, err
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fib_seq_ctrl
// Sequencer for a Fibonacci generator. Two seed writes are followed by one
// sum write per cycle (rf[addr1] + rf[addr2] -> addr3) until len terms have
// been written, then a one-cycle done pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fib_seq_ctrl_if.slave (start/len/abort in, control/status out)
// Every output is a flop loaded from the next-state decode, so no input
// reaches an output combinationally and each output is valid for the whole
// cycle of the state it belongs to.
// -----------------------------------------------------------------------------
module fib_seq_ctrl (
  input  logic           clk,
  input  logic           rst,
  fib_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED0 = 3'd1,
    SEED1 = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SRC_SEED_A = 2'd0;
  localparam logic [1:0] SRC_SEED_B = 2'd1;
  localparam logic [1:0] SRC_SUM    = 2'd2;
  localparam logic [5:0] MIN_LEN    = 6'd3;

  state_t     state, state_n;
  logic [5:0] len_q, len_n;
  logic       wer_q, wer_n;
  logic       wea_q, wea_n;
  logic [5:0] addr1_q, addr1_n;
  logic [5:0] addr2_q, addr2_n;
  logic [5:0] addr3_q, addr3_n;
  logic [1:0] src_sel_q, src_sel_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic       err_q, err_n;

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n = state;
    len_n   = len_q;
    addr1_n = 6'd0;
    addr2_n = 6'd1;
    addr3_n = 6'd0;
    err_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.len >= MIN_LEN) begin
            state_n = SEED0;
            len_n   = bus.len;
          end else begin
            err_n   = 1'b1;
          end
        end
      end

      SEED0: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          state_n = SEED1;
          addr3_n = 6'd1;
        end
      end

      SEED1: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          state_n = CALC;
          addr3_n = 6'd2;
        end
      end

      CALC: begin
        // Abort has priority over the final write so no done is reported.
        if (bus.abort) begin
          state_n = IDLE;
        end else if (addr3_q == len_q - 6'd1) begin
          state_n = DONE;
        end else begin
          state_n = CALC;
          // len_q <= 63 keeps addr3 <= 62, so these never wrap.
          addr1_n = addr1_q + 6'd1;
          addr2_n = addr2_q + 6'd1;
          addr3_n = addr3_q + 6'd1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Output flags follow purely from the state being entered.
    wer_n     = (state_n == SEED0) || (state_n == SEED1) || (state_n == CALC);
    wea_n     = wer_n;
    busy_n    = wer_n;
    done_n    = (state_n == DONE);
    src_sel_n = (state_n == SEED1) ? SRC_SEED_B :
                (state_n == CALC)  ? SRC_SUM    : SRC_SEED_A;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= 6'd0;
      wer_q     <= 1'b0;
      wea_q     <= 1'b0;
      addr1_q   <= 6'd0;
      addr2_q   <= 6'd1;
      addr3_q   <= 6'd0;
      src_sel_q <= SRC_SEED_A;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state     <= state_n;
      len_q     <= len_n;
      wer_q     <= wer_n;
      wea_q     <= wea_n;
      addr1_q   <= addr1_n;
      addr2_q   <= addr2_n;
      addr3_q   <= addr3_n;
      src_sel_q <= src_sel_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  assign bus.wer     = wer_q;
  assign bus.wea     = wea_q;
  assign bus.addr1   = addr1_q;
  assign bus.addr2   = addr2_q;
  assign bus.addr3   = addr3_q;
  assign bus.src_sel = src_sel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fib_seq_ctrl
// Directed bench for fib_seq_ctrl. Inputs change just after a rising edge or
// on the falling edge; outputs are sampled on the falling edge. A small
// datapath model (seeds 1,1 and a 32-bit adder) fills a RAM image from the
// controller's write strobes so the generated sequence can be compared
// against hand-computed Fibonacci numbers.
// -----------------------------------------------------------------------------
module tb_fib_seq_ctrl;

  logic clk = 1'b0;
  logic rst;

  fib_seq_ctrl_if bus ();

  fib_seq_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Datapath model: RAM image written on each strobe, sampled mid-cycle.
  logic [31:0] ram [0:63];
  always @(negedge clk) begin
    if (bus.wea === 1'b1) begin
      case (bus.src_sel)
        2'd0:    ram[bus.addr3] = 32'd1;
        2'd1:    ram[bus.addr3] = 32'd1;
        2'd2:    ram[bus.addr3] = ram[bus.addr1] + ram[bus.addr2];
        default: ram[bus.addr3] = 32'hdead_beef;
      endcase
    end
  end

  // Present start/len so it is sampled at the next rising edge (E0).
  task automatic issue_start(input logic [5:0] n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = n;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_wer"},  bus.wer,  0);
    check({tag, "_wea"},  bus.wea,  0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_a3"},   bus.addr3, 0);
  endtask

  // Check cycles 1..n of a full sequence plus the done cycle and after.
  task automatic run_seq(input logic [5:0] n);
    issue_start(n);
    for (int c = 1; c <= int'(n); c++) begin
      @(negedge clk);
      check("wer",  bus.wer,  1);
      check("wea",  bus.wea,  1);
      check("busy", bus.busy, 1);
      check("done", bus.done, 0);
      check("addr3", bus.addr3, c - 1);
      check("src_sel", bus.src_sel, (c == 1) ? 0 : (c == 2) ? 1 : 2);
      if (c >= 3) begin
        check("addr1", bus.addr1, c - 3);
        check("addr2", bus.addr2, c - 2);
      end
    end
    @(negedge clk);
    check("done_pulse", bus.done, 1);
    check("done_busy",  bus.busy, 0);
    check("done_wer",   bus.wer,  0);
    check("done_wea",   bus.wea,  0);
    @(negedge clk);
    check("post_done", bus.done, 0);
    check_idle("post");
  endtask

  int unsigned fib8 [8] = '{1, 1, 2, 3, 5, 8, 13, 21};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.len   = 6'd0;
    bus.abort = 1'b0;
    rst       = 1'b1;
    #2;
    check("rst_addr1",   bus.addr1,   0);
    check("rst_addr2",   bus.addr2,   1);
    check("rst_addr3",   bus.addr3,   0);
    check("rst_src_sel", bus.src_sel, 0);
    check("rst_err",     bus.err,     0);
    check_idle("rst");
    @(negedge clk);
    rst = 1'b0;

    // Full sequence of 8 terms and the resulting RAM contents.
    run_seq(6'd8);
    for (int i = 0; i < 8; i++) check("ram8", ram[i], fib8[i]);

    // Shortest legal sequence: exactly one CALC cycle.
    run_seq(6'd3);

    // Invalid lengths: err pulse, no activity.
    begin
      logic [5:0] bad [2] = '{6'd2, 6'd0};
      for (int k = 0; k < 2; k++) begin
        issue_start(bad[k]);
        @(negedge clk);
        check("err_pulse", bus.err, 1);
        check_idle("err");
        @(negedge clk);
        check("err_clear", bus.err, 0);
        check_idle("err2");
      end
    end

    // Abort while idle does nothing.
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("idle_abort");

    // Longest sequence: last write at 62, no wrap.
    run_seq(6'd63);

    // Abort in cycle 5 (addr3=4) of a 10-term run.
    issue_start(6'd10);
    repeat (5) @(negedge clk);
    check("ab_addr3", bus.addr3, 4);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_idle("abort");
    end
    run_seq(6'd5);

    // Abort coinciding with the last CALC cycle: no done.
    issue_start(6'd5);
    repeat (5) @(negedge clk);
    check("ablast_addr3", bus.addr3, 4);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check_idle("ablast");
    @(negedge clk);
    check_idle("ablast2");

    // Second start in cycle 4 ignored; then reset mid-CALC.
    issue_start(6'd10);
    repeat (4) @(negedge clk);
    check("re_addr3_c4", bus.addr3, 3);
    bus.start = 1'b1;
    bus.len   = 6'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("re_addr3_c5", bus.addr3, 4);
    check("re_src_c5",   bus.src_sel, 2);
    @(negedge clk);
    check("re_addr3_c6", bus.addr3, 5);
    check("re_busy_c6",  bus.busy, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_addr1", bus.addr1, 0);
    check("arst_addr2", bus.addr2, 1);
    check("arst_src",   bus.src_sel, 0);
    check("arst_err",   bus.err, 0);
    check_idle("arst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle("post_rst");
    end

    // Controller still works after reset.
    run_seq(6'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; forces reset state immediately, released synchronously to clk.
REQ-003 start  input  1  request to generate a sequence; sampled only in IDLE.
REQ-004 len  input  6  total terms to generate (seeds included); valid range 3..63; sampled with start.
REQ-005 abort  input  1  cancel a running sequence.
REQ-006 wer  output  1  register-file write enable.
REQ-007 wea  output  1  RAM write enable.
REQ-008 addr1  output  6  register-file read address A (older operand).
REQ-009 addr2  output  6  register-file read address B (newer operand).
REQ-010 addr3  output  6  write address, shared by register file and RAM.
REQ-011 src_sel  output  2  write-data mux: 0 = seed A, 1 = seed B, 2 = ALU sum, 3 = unused.
REQ-012 busy  output  1  high while SEED0, SEED1 or CALC.
REQ-013 done  output  1  single-cycle pulse on normal completion.
REQ-014 err  output  1  single-cycle pulse when start is rejected for an invalid len.

Function
REQ-015 All outputs SHALL be registered and decoded from state registers only; there are no combinational input-to-output paths.
REQ-016 States SHALL be IDLE, SEED0, SEED1, CALC and DONE.
REQ-017 IDLE: wer=0, wea=0, busy=0, done=0, src_sel=0, and addr1/addr2/addr3 SHALL hold 0/1/0.
REQ-018 IDLE with start=1 and 3<=len<=63 SHALL latch len into len_q and go to SEED0.
REQ-019 IDLE with start=1 and len<3 SHALL pulse err for one cycle and stay in IDLE.
REQ-020 SEED0 (one cycle): wer=1, wea=1, addr3=0, src_sel=0; next state SEED1.
REQ-021 SEED1 (one cycle): wer=1, wea=1, addr3=1, src_sel=1; next state CALC with addr1=0, addr2=1, addr3=2.
REQ-022 CALC: wer=1, wea=1, src_sel=2; datapath writes rf[addr1]+rf[addr2] to addr3.
REQ-023 CALC: while addr3 != len_q-1, addr1, addr2 and addr3 SHALL each increment by 1 every cycle.
REQ-024 CALC: when addr3 == len_q-1, that cycle is the last write; next state DONE.
REQ-025 DONE (one cycle): done=1, busy=0, wer=0, wea=0; next state IDLE.
REQ-026 Cycle budget: with start accepted at edge E0, the sequence SHALL run SEED0 in cycle 1, SEED1 in cycle 2, CALC in cycles 3..len_q and DONE in cycle len_q+1.
REQ-027 Address arithmetic SHALL be 6-bit and can never wrap, because len_q<=63 bounds addr3 to at most 62.
REQ-028 start while busy or in DONE SHALL be ignored, and len_q SHALL not change.
REQ-029 abort in SEED0, SEED1 or CALC SHALL force IDLE at the next edge with no done pulse; the write in the abort cycle still completes.
REQ-030 If abort and the last CALC cycle coincide, abort wins: no done pulse.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 The controller SHALL never assert wer or wea outside SEED0, SEED1 and CALC.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, wer=0, wea=0, addr1=0, addr2=1, addr3=0, src_sel=0, busy=0, done=0, err=0 and len_q=0.
REQ-034 rst asserted mid-sequence SHALL abort with no done pulse; the first edge after release SHALL be an IDLE cycle.

Verification
REQ-035 rst pulse, then start=1, len=8 -> writes to addr3 0,1,2..7 in cycles 1..8; done in cycle 9; RAM holds 1,1,2,3,5,8,13,21 for seeds 1,1.
REQ-036 start=1, len=3 -> exactly one CALC cycle (addr1=0, addr2=1, addr3=2); done in cycle 4.
REQ-037 start=1, len=2, then len=0 -> err pulses, busy stays 0, no writes.
REQ-038 start=1, len=63 -> last write at addr3=62 in cycle 63; done in cycle 64; no address wrap.
REQ-039 len=10, abort in cycle 5 (addr3=4) -> IDLE next edge, no done; a new start with len=5 completes normally.
REQ-040 len=10, start pulsed again in cycle 4 with len=3, then rst asserted mid-CALC -> second start ignored; on rst all outputs reach reset values without a clock edge.
